mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbiter and sequencer for the single-ported SISC main memory.
- Shares the memory between two requesters: the instruction-fetch path (IF) and the load/store data path (DM).
- Issues one access at a time, holds off new grants while a read is outstanding, and returns read data with a valid pulse.
- Sits between the control FSM/datapath and the memory macro.

Parameters:
ADDR_W, 16, width of memory address
DATA_W, 32, width of memory data word
MEM_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..3

Ports:
clk  input  1  system clock, rising edge
rst_f  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held high until if_gnt
if_addr  input  ADDR_W  fetch address, stable while if_req
if_gnt  output  1  one-cycle pulse: fetch access issued this cycle
if_rdata  output  DATA_W  fetched word
if_valid  output  1  one-cycle pulse: if_rdata valid
dm_req  input  1  data request; held high until dm_gnt
dm_we  input  1  1 = store, 0 = load; stable while dm_req
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_gnt  output  1  one-cycle pulse: data access issued this cycle
dm_rdata  output  DATA_W  loaded word
dm_valid  output  1  one-cycle pulse: dm_rdata valid (loads only)
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high in any state other than IDLE

Behaviour:
- The only clock is clk. Reset rst_f is asynchronous and active-low.
- Reset values: state = IDLE, last_dm = 0, lat_cnt = 0. All of the following are 0: gnt, valid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, busy.
- States are IDLE, ISSUE, RD_WAIT.
- IDLE, arbitration on the registered request inputs:
  - Only one requester active: that requester wins.
  - Both active: DM wins unless last_dm = 1, in which case IF wins (alternating, starvation-free).
  - Move to ISSUE with the winner latched.
- ISSUE (one cycle):
  - mem_en = 1; mem_addr, mem_we and mem_wdata are driven combinationally from the latched winner's inputs.
  - The winner's gnt pulses high. last_dm is set to 1 if DM won, otherwise 0.
  - IF accesses always have mem_we = 0.
  - Store: mem_we = 1, no valid pulse; go to IDLE.
  - Load or fetch: load lat_cnt = MEM_LAT; go to RD_WAIT.
- RD_WAIT:
  - lat_cnt decrements each cycle.
  - At lat_cnt = 1: capture mem_rdata into the owner's rdata register and pulse the owner's valid on the following cycle (registered output); go to IDLE.
  - No grant is issued while in RD_WAIT.
- Latency:
  - req high in IDLE at edge N -> gnt/mem_en in cycle N+1.
  - Read valid in cycle N+1+MEM_LAT+1.
  - Back-to-back stores: one grant every 2 cycles.
- Requesters must drop req in the cycle after gnt, or a second access is issued. A request still high in IDLE is treated as new.
- rdata registers hold their value until the next read for the same requester.
- Request deasserted before grant: dropped, no access issued.
- Reset mid-read: outstanding read abandoned, no valid pulse; state returns to IDLE.
- Simultaneous release/request: a request arriving in the same cycle a valid pulses is evaluated in the following IDLE cycle.
- busy = 1 in ISSUE and RD_WAIT.

Test Plan:
- Reset, MEM_LAT=1, if_req with if_addr=0x0010, memory word 0x12345678 -> if_gnt one cycle later with mem_addr=0x0010 and mem_we=0; if_valid two cycles after gnt with if_rdata=0x12345678.
- dm_req store, dm_addr=0x0040, dm_wdata=0xDEADBEEF -> dm_gnt with mem_we=1 and mem_wdata=0xDEADBEEF; no dm_valid; subsequent load of 0x0040 returns 0xDEADBEEF.
- if_req and dm_req high together from reset -> DM granted first; IF granted next; with both held, the next two grants alternate DM, IF.
- MEM_LAT=3, load issued, if_req raised during RD_WAIT -> no if_gnt until dm_valid pulses; if_gnt follows in the next cycle.
- Load issued, rst_f pulled low for one cycle during RD_WAIT -> no dm_valid; busy=0 and all outputs 0 immediately; next request served normally.
- dm_req raised then dropped before grant while a fetch is outstanding -> no dm_gnt, no mem write.

Source files
------------

// File: rtl/mem_arb.sv
// Purpose: arbitrates the single-ported main memory between instruction fetch (IF) and load/store (DM).
// Latency: grant one cycle after a request is seen in IDLE; read data valid MEM_LAT+1 cycles after the grant.
// Backpressure: one access in flight; requests are ignored outside IDLE and must be held until granted.
module mem_arb #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   // Counter only needs to cover MEM_LAT up to 3.
   localparam logic [1:0] LAT_INIT = MEM_LAT[1:0];

   state_t              state_q;
   logic                win_dm_q;
   logic                last_dm_q;
   logic [1:0]          lat_cnt_q;
   logic                if_gnt_q, dm_gnt_q;
   logic                mem_en_q, mem_we_q;
   logic                if_valid_q, dm_valid_q;
   logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
   logic                win_dm_d;

   // DM wins a tie unless it won the previous tie-able access, so neither side starves.
   assign win_dm_d = dm_req && (!if_req || !last_dm_q);

   // Address/data follow the latched winner's live inputs during the issue cycle only.
   assign mem_addr  = mem_en_q ? (win_dm_q ? dm_addr : if_addr) : '0;
   assign mem_wdata = mem_we_q ? dm_wdata : '0;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = (state_q != IDLE);

   // Sequencer: IDLE arbitrates, ISSUE strobes the memory, RD_WAIT counts down and returns read data.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q    <= IDLE;
         win_dm_q   <= 1'b0;
         last_dm_q  <= 1'b0;
         lat_cnt_q  <= '0;
         if_gnt_q   <= 1'b0;
         dm_gnt_q   <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         // Grant, strobe and valid are single-cycle pulses.
         if_gnt_q   <= 1'b0;
         dm_gnt_q   <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_req || dm_req) begin
                  win_dm_q <= win_dm_d;
                  dm_gnt_q <= win_dm_d;
                  if_gnt_q <= !win_dm_d;
                  mem_en_q <= 1'b1;
                  mem_we_q <= win_dm_d && dm_we;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               last_dm_q <= win_dm_q;
               if (mem_we_q) begin
                  state_q <= IDLE;
               end else begin
                  lat_cnt_q <= LAT_INIT;
                  state_q   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               lat_cnt_q <= lat_cnt_q - 2'd1;
               if (lat_cnt_q == 2'd1) begin
                  if (win_dm_q) begin
                     dm_rdata_q <= mem_rdata;
                     dm_valid_q <= 1'b1;
                  end else begin
                     if_rdata_q <= mem_rdata;
                     if_valid_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Purpose: directed checks of mem_arb with MEM_LAT=1 (instance a) and MEM_LAT=3 (instance b).
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: each memory model returns data MEM_LAT cycles after a read strobe.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        if_req, dm_req, dm_we;
   logic [15:0] if_addr, dm_addr;
   logic [31:0] dm_wdata;

   logic        a_if_gnt, a_if_valid, a_dm_gnt, a_dm_valid, a_mem_en, a_mem_we, a_busy;
   logic [31:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
   logic [15:0] a_mem_addr;
   logic        b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid, b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
   logic [15:0] b_mem_addr;

   logic [31:0] mema [256];
   logic [31:0] memb [256];
   logic [31:0] a_pipe;
   logic [31:0] b_pipe [3];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u_a (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(a_dm_gnt), .dm_rdata(a_dm_rdata), .dm_valid(a_dm_valid),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy));

   mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) u_b (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(b_dm_gnt), .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy));

   // Memory models: write on strobe, read data appears MEM_LAT cycles after the strobe.
   always @(posedge clk) begin
      if (a_mem_en && a_mem_we) mema[a_mem_addr[7:0]] <= a_mem_wdata;
      a_pipe <= (a_mem_en && !a_mem_we) ? mema[a_mem_addr[7:0]] : 32'hBAD0BAD0;
      if (b_mem_en && b_mem_we) memb[b_mem_addr[7:0]] <= b_mem_wdata;
      b_pipe[0] <= (b_mem_en && !b_mem_we) ? memb[b_mem_addr[7:0]] : 32'hBAD0BAD0;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign a_mem_rdata = a_pipe;
   assign b_mem_rdata = b_pipe[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if_req = 0; dm_req = 0; dm_we = 0;
      rst_f = 0;
      tick();
      rst_f = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_f = 0; if_req = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) tick();
      if ({a_if_gnt, a_dm_gnt, a_if_valid, a_dm_valid, a_mem_en, a_mem_we, a_busy} !== 7'b0) begin
         $display("FAIL reset_ctl: got %b want 0000000",
                  {a_if_gnt, a_dm_gnt, a_if_valid, a_dm_valid, a_mem_en, a_mem_we, a_busy});
         n_bad++;
      end
      n_vec++;
      if ({a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata} !== 112'b0) begin
         $display("FAIL reset_dat: got %h want 0", {a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata});
         n_bad++;
      end
      n_vec++;
      rst_f = 1;
      tick();
      if ({a_busy, a_mem_en} !== 2'b00) begin
         $display("FAIL reset_idle: got %b want 00", {a_busy, a_mem_en});
         n_bad++;
      end
      n_vec++;
   endtask

   task automatic test_fetch();
      do_reset();
      if_req = 1; if_addr = 16'h0010;
      tick();
      if ({a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_busy, a_mem_addr} !== {5'b10101, 16'h0010}) begin
         $display("FAIL fetch_gnt: got %b_%h want 10101_0010",
                  {a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_busy}, a_mem_addr);
         n_bad++;
      end
      n_vec++;
      if_req = 0;
      tick();
      if ({a_if_valid, a_busy, a_if_gnt} !== 3'b010) begin
         $display("FAIL fetch_wait: got %b want 010", {a_if_valid, a_busy, a_if_gnt});
         n_bad++;
      end
      n_vec++;
      tick();
      if ({a_if_valid, a_dm_valid, a_busy, a_if_rdata} !== {3'b100, 32'h12345678}) begin
         $display("FAIL fetch_valid: got %b_%h want 100_12345678", {a_if_valid, a_dm_valid, a_busy}, a_if_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
      if ({a_if_valid, a_if_rdata} !== {1'b0, 32'h12345678}) begin
         $display("FAIL fetch_hold: got %b_%h want 0_12345678", a_if_valid, a_if_rdata);
         n_bad++;
      end
      n_vec++;
   endtask

   task automatic test_store_load();
      logic seen_valid;
      do_reset();
      dm_req = 1; dm_we = 1; dm_addr = 16'h0040; dm_wdata = 32'hDEADBEEF;
      tick();
      if ({a_dm_gnt, a_if_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {4'b1011, 16'h0040, 32'hDEADBEEF}) begin
         $display("FAIL store_gnt: got %b_%h_%h want 1011_0040_deadbeef",
                  {a_dm_gnt, a_if_gnt, a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata);
         n_bad++;
      end
      n_vec++;
      dm_req = 0;
      seen_valid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_dm_valid) seen_valid = 1;
      end
      if (seen_valid !== 1'b0) begin
         $display("FAIL store_novalid: got %b want 0", seen_valid);
         n_bad++;
      end
      n_vec++;
      dm_req = 1; dm_we = 0;
      tick();
      if ({a_dm_gnt, a_mem_en, a_mem_we} !== 3'b110) begin
         $display("FAIL load_gnt: got %b want 110", {a_dm_gnt, a_mem_en, a_mem_we});
         n_bad++;
      end
      n_vec++;
      dm_req = 0;
      tick();
      tick();
      if ({a_dm_valid, a_if_valid, a_dm_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         $display("FAIL load_data: got %b_%h want 10_deadbeef", {a_dm_valid, a_if_valid}, a_dm_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
   endtask

   task automatic test_alternate();
      logic [3:0] seq;
      int         ng;
      int         first;
      logic       both;
      do_reset();
      seq = '0; ng = 0; first = 0; both = 0;
      if_req = 1; if_addr = 16'h0010;
      dm_req = 1; dm_we = 1; dm_addr = 16'h0050; dm_wdata = 32'h0000A5A5;
      for (int i = 1; i <= 40 && ng < 4; i++) begin
         tick();
         if (a_if_gnt && a_dm_gnt) both = 1;
         if (a_dm_gnt || a_if_gnt) begin
            if (ng == 0) first = i;
            seq = {seq[2:0], a_dm_gnt};
            ng++;
         end
      end
      if_req = 0; dm_req = 0;
      if (ng !== 4) begin
         $display("FAIL alt_count: got %0d grants want 4 (cycle budget expired)", ng);
         n_bad++;
      end
      n_vec++;
      if ({seq, both} !== 5'b10100) begin
         $display("FAIL alt_order: got seq %b both %b want seq 1010 both 0", seq, both);
         n_bad++;
      end
      n_vec++;
      if (first !== 1) begin
         $display("FAIL alt_first: got cycle %0d want 1", first);
         n_bad++;
      end
      n_vec++;
      repeat (4) tick();
   endtask

   task automatic test_back_to_back();
      logic [5:0] pat;
      do_reset();
      pat = '0;
      dm_req = 1; dm_we = 1; dm_addr = 16'h0070; dm_wdata = 32'h01020304;
      for (int i = 0; i < 6; i++) begin
         tick();
         pat = {pat[4:0], a_dm_gnt};
      end
      dm_req = 0;
      if (pat !== 6'b101010) begin
         $display("FAIL b2b_store: got %b want 101010", pat);
         n_bad++;
      end
      n_vec++;
      repeat (2) tick();
   endtask

   task automatic test_lat3();
      int   n;
      logic found, early;
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
      tick();
      if ({b_dm_gnt, b_mem_en, b_mem_we, b_mem_addr} !== {3'b110, 16'h0020}) begin
         $display("FAIL lat3_gnt: got %b_%h want 110_0020", {b_dm_gnt, b_mem_en, b_mem_we}, b_mem_addr);
         n_bad++;
      end
      n_vec++;
      dm_req = 0; if_req = 1; if_addr = 16'h0030;
      n = 0; found = 0; early = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         n++;
         if (b_if_gnt) early = 1;
         if (b_dm_valid) found = 1;
      end
      if ({found, early} !== 2'b10 || n !== 4) begin
         $display("FAIL lat3_valid: got found %b early_gnt %b after %0d cycles want 1 0 after 4", found, early, n);
         n_bad++;
      end
      n_vec++;
      if (b_dm_rdata !== 32'hCAFEF00D) begin
         $display("FAIL lat3_data: got %h want cafef00d", b_dm_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
      if ({b_if_gnt, b_mem_addr} !== {1'b1, 16'h0030}) begin
         $display("FAIL lat3_ifgnt: got %b_%h want 1_0030", b_if_gnt, b_mem_addr);
         n_bad++;
      end
      n_vec++;
      if_req = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (b_if_valid) found = 1;
      end
      if ({found, b_if_rdata} !== {1'b1, 32'h30303030}) begin
         $display("FAIL lat3_fetch: got %b_%h want 1_30303030", found, b_if_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
   endtask

   task automatic test_reset_mid_read();
      logic seen, found;
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
      tick();
      dm_req = 0;
      tick();
      rst_f = 0;
      #1;
      if ({b_busy, b_mem_en, b_mem_we, b_dm_gnt, b_dm_valid, b_mem_addr, b_dm_rdata} !== 53'b0) begin
         $display("FAIL midrst_clear: got %b_%h_%h want 00000_0000_00000000",
                  {b_busy, b_mem_en, b_mem_we, b_dm_gnt, b_dm_valid}, b_mem_addr, b_dm_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
      rst_f = 1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b_dm_valid || b_busy) seen = 1;
      end
      if (seen !== 1'b0) begin
         $display("FAIL midrst_novalid: got %b want 0", seen);
         n_bad++;
      end
      n_vec++;
      if_req = 1; if_addr = 16'h0010;
      tick();
      if (b_if_gnt !== 1'b1) begin
         $display("FAIL midrst_next_gnt: got %b want 1", b_if_gnt);
         n_bad++;
      end
      n_vec++;
      if_req = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (b_if_valid) found = 1;
      end
      if ({found, b_if_rdata} !== {1'b1, 32'h55AA55AA}) begin
         $display("FAIL midrst_next_data: got %b_%h want 1_55aa55aa", found, b_if_rdata);
         n_bad++;
      end
      n_vec++;
      tick();
   endtask

   task automatic test_drop_before_grant();
      logic bad, got_valid;
      do_reset();
      if_req = 1; if_addr = 16'h0030;
      tick();
      if (b_if_gnt !== 1'b1) begin
         $display("FAIL drop_ifgnt: got %b want 1", b_if_gnt);
         n_bad++;
      end
      n_vec++;
      if_req = 0;
      dm_req = 1; dm_we = 1; dm_addr = 16'h0060; dm_wdata = 32'h11111111;
      bad = 0; got_valid = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (b_dm_gnt || b_mem_we) bad = 1;
      end
      dm_req = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (b_dm_gnt || b_mem_we) bad = 1;
         if (b_if_valid) got_valid = 1;
      end
      if ({bad, got_valid} !== 2'b01) begin
         $display("FAIL drop_noaccess: got bad %b fetch_valid %b want 0 1", bad, got_valid);
         n_bad++;
      end
      n_vec++;
      if (memb[8'h60] !== 32'h0) begin
         $display("FAIL drop_memword: got %h want 00000000", memb[8'h60]);
         n_bad++;
      end
      n_vec++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mema[i] = '0;
         memb[i] = '0;
      end
      mema[8'h10] = 32'h12345678;
      memb[8'h10] = 32'h55AA55AA;
      memb[8'h20] = 32'hCAFEF00D;
      memb[8'h30] = 32'h30303030;
      test_reset();
      test_fetch();
      test_store_load();
      test_alternate();
      test_back_to_back();
      test_lat3();
      test_reset_mid_read();
      test_drop_before_grant();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
